// File: rtl/console_uart_tx.sv
// Console output stage on the look-ahead memory bus: console byte writes go through a FIFO
// and are sent as 8N1 UART frames; a status word reports FIFO level, busy and dropped bytes.
module console_uart_tx #(
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter logic [31:0] STATUS_ADDR  = 32'h1000_0004,
    parameter int unsigned CLK_DIV      = 16,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_la_read,
    input  logic        mem_la_write,
    input  logic [31:0] mem_la_addr,
    input  logic [31:0] mem_la_wdata,
    input  logic [3:0]  mem_la_wstrb,
    output logic [31:0] status_rdata,
    output logic        status_valid,
    output logic        uart_tx,
    output logic        busy,
    output logic [15:0] drop_count,
    output logic [1:0]  state_dbg
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state, state_n;
    logic [DIV_W-1:0]   div_cnt, div_n;
    logic [2:0]         bit_cnt, bit_n;
    logic [7:0]         shift_q, shift_n;
    logic               pop;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [7:0]         level;
    logic               empty, full, div_last;
    logic               push_req, push_ok, read_hit;

    logic unused_bits;
    assign unused_bits = ^{mem_la_wdata[31:8], mem_la_wstrb[3:1]};

    assign push_req = mem_la_write && (mem_la_addr == CONSOLE_ADDR) && mem_la_wstrb[0];
    assign read_hit = mem_la_read && (mem_la_addr == STATUS_ADDR);
    assign empty    = (level == 8'd0);
    assign full     = (level == 8'(FIFO_DEPTH));
    // A full FIFO still accepts a push when the FSM pops on the same edge.
    assign push_ok  = push_req && (!full || pop);
    assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign busy     = (state != IDLE) || !empty;
    assign state_dbg = state;

    always_comb begin
        state_n = state;
        div_n   = div_cnt;
        bit_n   = bit_cnt;
        shift_n = shift_q;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    div_n   = '0;
                    state_n = START;
                end
            end
            START: begin
                if (div_last) begin
                    div_n   = '0;
                    bit_n   = 3'd0;
                    state_n = DATA;
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
            DATA: begin
                if (div_last) begin
                    div_n   = '0;
                    shift_n = {1'b0, shift_q[7:1]};
                    if (bit_cnt == 3'd7) state_n = STOP;
                    else                 bit_n   = bit_cnt + 3'd1;
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
            STOP: begin
                if (div_last) begin
                    div_n = '0;
                    // Chain straight into the next frame so queued bytes leave without a gap.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr];
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= 3'd0;
            shift_q <= 8'd0;
        end else begin
            state   <= state_n;
            div_cnt <= div_n;
            bit_cnt <= bit_n;
            shift_q <= shift_n;
        end
    end

    // Line level decoded from registered state only, so reset returns the pin high next cycle.
    always_comb begin
        uart_tx = 1'b1;
        case (state)
            START:   uart_tx = 1'b0;
            DATA:    uart_tx = shift_q[0];
            default: uart_tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= mem_la_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= 8'd0;
            drop_count <= 16'd0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   level <= level + 8'd1;
                2'b01:   level <= level - 8'd1;
                default: level <= level;
            endcase
            if (push_req && !push_ok && (drop_count != 16'hFFFF))
                drop_count <= drop_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            status_valid <= 1'b0;
            status_rdata <= 32'd0;
        end else begin
            status_valid <= read_hit;
            if (read_hit)
                status_rdata <= {drop_count, level, 5'b0, busy, full, empty};
        end
    end
endmodule
